// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file and the writeback stage.
//   XLEN_D / NREGS_D / NREAD_D : default data width, register count, read ports
//   wb_req_t                   : writeback request {we, wa, wd} at default sizes
package regfile_pkg;

  localparam int unsigned XLEN_D  = 32;
  localparam int unsigned NREGS_D = 32;
  localparam int unsigned NREAD_D = 2;
  localparam int unsigned AW_D    = $clog2(NREGS_D);

  typedef struct packed {
    logic            we;
    logic [AW_D-1:0] wa;
    logic [XLEN_D-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/regfile_sb.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback. Exposes the registered vector and its next-state value.
//   clk, rst_n          : clock, synchronous active-low reset
//   set_en, set_addr    : issue strobe and destination register
//   clr_en, clr_addr    : writeback strobe and written register
//   pend                : current pending vector
//   pend_nxt            : pending vector after this cycle's clear and set
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_D,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] pend,
  output logic [NREGS-1:0] pend_nxt
);

  // Set is applied after clear so a simultaneous issue to the register
  // being written keeps it pending (the newer producer wins).
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_addr] = 1'b0;
    if (set_en) pend_nxt[set_addr] = 1'b1;
    if (ZERO_REG) pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending-write scoreboard.
// Registered reads (1-cycle latency), optional hardwired-zero register 0,
// optional same-cycle write-to-read bypass, per-port busy flags.
//   clk, rst_n : clock, synchronous active-low reset
//   rd_addr    : NREAD read addresses (packed)
//   rd_data    : NREAD registered read data
//   rd_busy    : NREAD registered busy flags
//   we, wa, wd : writeback port
//   iss_valid, iss_rd : issue strobe and destination register
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_D,
  parameter int unsigned NREGS    = NREGS_D,
  parameter int unsigned NREAD    = NREAD_D,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREAD-1:0][AW-1:0]   rd_addr,
  output logic [NREAD-1:0][XLEN-1:0] rd_data,
  output logic [NREAD-1:0]           rd_busy,
  input  logic                       we,
  input  logic [AW-1:0]              wa,
  input  logic [XLEN-1:0]            wd,
  input  logic                       iss_valid,
  input  logic [AW-1:0]              iss_rd
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic             wr_ok;
  logic             iss_ok;

  logic [NREAD-1:0][XLEN-1:0] rd_data_nxt;
  logic [NREAD-1:0]           rd_busy_nxt;

  // Writes and issues targeting a hardwired-zero register 0 are dropped.
  assign wr_ok  = we        && !(ZERO_REG && (wa == '0));
  assign iss_ok = iss_valid && !(ZERO_REG && (iss_rd == '0));

  regfile_sb #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_ok),
    .set_addr (iss_rd),
    .clr_en   (wr_ok),
    .clr_addr (wa),
    .pend     (pend),
    .pend_nxt (pend_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  // With bypass the port sees this cycle's write data and the scoreboard's
  // next state; without it, the pre-edge array contents and pending bits.
  always_comb begin
    rd_data_nxt = '0;
    rd_busy_nxt = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      if (ZERO_REG && (rd_addr[p] == '0)) begin
        rd_data_nxt[p] = '0;
        rd_busy_nxt[p] = 1'b0;
      end else begin
        if (BYPASS && wr_ok && (wa == rd_addr[p])) rd_data_nxt[p] = wd;
        else                                       rd_data_nxt[p] = mem[rd_addr[p]];
        rd_busy_nxt[p] = BYPASS ? pend_nxt[rd_addr[p]] : pend[rd_addr[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      rd_data <= rd_data_nxt;
      rd_busy <= rd_busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  // Shared stimulus for instance A (ZERO_REG=1, BYPASS=1) and B (ZERO_REG=0, BYPASS=0)
  logic [1:0][4:0]  rd_addr;
  logic             we;
  logic [4:0]       wa;
  logic [31:0]      wd;
  logic             iss_valid;
  logic [4:0]       iss_rd;
  logic [1:0][31:0] a_data, b_data;
  logic [1:0]       a_busy, b_busy;

  // Wide instance C
  logic [3:0][5:0]  c_addr;
  logic             c_we;
  logic [5:0]       c_wa;
  logic [63:0]      c_wd;
  logic [3:0][63:0] c_data;
  logic [3:0]       c_busy;

  int unsigned n_vec;
  int unsigned n_err;
  logic [63:0] mdl [64];
  int unsigned ra [4];

  regfile_mp u_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(a_data), .rd_busy(a_busy),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd)
  );

  regfile_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(b_data), .rd_busy(b_busy),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd)
  );

  regfile_mp #(.XLEN(64), .NREGS(64), .NREAD(4)) u_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(c_addr), .rd_data(c_data), .rd_busy(c_busy),
    .we(c_we), .wa(c_wa), .wd(c_wd), .iss_valid(1'b0), .iss_rd(6'd0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we        = 1'b0;
    iss_valid = 1'b0;
  endtask

  // Port 0 data and busy of both A and B
  task automatic chk_p0(input string tag, input logic [31:0] ea, input logic eab,
                        input logic [31:0] eb, input logic ebb);
    check({tag, " A.data"}, a_data[0], ea);
    check({tag, " A.busy"}, a_busy[0], eab);
    check({tag, " B.data"}, b_data[0], eb);
    check({tag, " B.busy"}, b_busy[0], ebb);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; we = 1'b1; wa = 5'd5; wd = 32'hFF; iss_valid = 1'b1; iss_rd = 5'd5;
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
    c_we = 1'b0; c_wa = '0; c_wd = '0; c_addr = '0;

    // Reset dominates write and issue
    step();
    chk_p0("rst", 32'h0, 1'b0, 32'h0, 1'b0);
    check("rst C.data", c_data[0], 64'h0);
    rst_n = 1'b1; idle();
    step();
    chk_p0("post_rst r5", 32'h0, 1'b0, 32'h0, 1'b0);

    // Write DEADBEEF to reg 5, read on both ports
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    step();
    chk_p0("wr5 same", 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    idle();
    step();
    check("wr5 A.p0", a_data[0], 32'hDEADBEEF);
    check("wr5 A.p1", a_data[1], 32'hDEADBEEF);
    check("wr5 B.p0", b_data[0], 32'hDEADBEEF);
    check("wr5 B.p1", b_data[1], 32'hDEADBEEF);

    // Register 0: hardwired in A, ordinary in B
    we = 1'b1; wa = 5'd0; wd = 32'h1234; iss_valid = 1'b1; iss_rd = 5'd0;
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
    step();
    chk_p0("r0 same", 32'h0, 1'b0, 32'h0, 1'b0);
    idle();
    step();
    chk_p0("r0 next", 32'h0, 1'b0, 32'h1234, 1'b1);

    // Same-cycle write/read of reg 7, old value 0x11
    we = 1'b1; wa = 5'd7; wd = 32'h11; rd_addr[0] = 5'd7; rd_addr[1] = 5'd7;
    step();
    wd = 32'hA5A5A5A5;
    step();
    chk_p0("r7 same", 32'hA5A5A5A5, 1'b0, 32'h11, 1'b0);
    idle();
    step();
    chk_p0("r7 next", 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0);

    // Scoreboard on reg 3 (port 1 watches reg 4, never busy)
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
    iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    chk_p0("iss3", 32'h0, 1'b1, 32'h0, 1'b0);
    check("iss3 A.busy1", a_busy[1], 1'b0);
    idle();
    step();
    chk_p0("iss3+1", 32'h0, 1'b1, 32'h0, 1'b1);
    we = 1'b1; wa = 5'd3; wd = 32'h33; iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    chk_p0("wr+iss3", 32'h33, 1'b1, 32'h0, 1'b1);
    idle();
    step();
    chk_p0("wr+iss3+1", 32'h33, 1'b1, 32'h33, 1'b1);
    we = 1'b1; wa = 5'd3; wd = 32'h44;
    step();
    chk_p0("clr3", 32'h44, 1'b0, 32'h33, 1'b1);
    idle();
    step();
    chk_p0("clr3+1", 32'h44, 1'b0, 32'h44, 1'b0);

    // Mid-stream reset with write and issue asserted
    rst_n = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'h99; iss_valid = 1'b1; iss_rd = 5'd9;
    rd_addr[0] = 5'd7; rd_addr[1] = 5'd9;
    step();
    chk_p0("mrst", 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1; idle();
    step();
    chk_p0("mrst r7", 32'h0, 1'b0, 32'h0, 1'b0);
    check("mrst A.busy9", a_busy[1], 1'b0);
    check("mrst B.busy9", b_busy[1], 1'b0);
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd3;
    step();
    chk_p0("mrst r5", 32'h0, 1'b0, 32'h0, 1'b0);
    check("mrst B.r3", b_data[1], 32'h0);

    // Wide instance: fill with index * 0x0101, then random 4-port reads
    for (int i = 0; i < 64; i++) begin
      mdl[i] = 64'(i) * 64'h0101;
      c_we = 1'b1; c_wa = 6'(i); c_wd = mdl[i];
      step();
    end
    c_we = 1'b0;
    for (int n = 0; n < 24; n++) begin
      for (int p = 0; p < 4; p++) begin
        ra[p] = $urandom_range(0, 63);
        c_addr[p] = 6'(ra[p]);
      end
      step();
      for (int p = 0; p < 4; p++) begin
        check($sformatf("C rd%0d a%0d", p, ra[p]), c_data[p], mdl[ra[p]]);
        check($sformatf("C busy%0d", p), c_busy[p], 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
